// File: rtl/wr_sched_pkg.sv
// Shared constants, types and the default per-row offset table for the write scheduler.
// The optional WR_SCHED_ITER_EN feature does not change anything in this package.
package wr_sched_pkg;

    localparam logic [3:0] FSM_IDLE = 4'b0001;
    localparam logic [3:0] FSM_LOAD = 4'b0010;
    localparam logic [3:0] FSM_UPD  = 4'b0100;
    localparam logic [3:0] FSM_DONE = 4'b1000;

    localparam logic [1:0] CYC_NONE = 2'd0;
    localparam logic [1:0] CYC_1    = 2'd1;
    localparam logic [1:0] CYC_2    = 2'd2;
    localparam logic [1:0] CYC_3    = 2'd3;

    localparam int ROW_W  = 4;
    localparam int OFF_FW = 8;

    typedef struct packed {
        logic [OFF_FW-1:0] c1;
        logic [OFF_FW-1:0] c2;
        logic [OFF_FW-1:0] c3;
    } off_triple_t;

    function automatic off_triple_t offset_tbl(input logic [ROW_W-1:0] row);
        case (row)
            4'd0:    return '{c1: 8'd1, c2: 8'd3, c3: 8'd5};
            4'd1:    return '{c1: 8'd2, c2: 8'd4, c3: 8'd6};
            4'd2:    return '{c1: 8'd0, c2: 8'd5, c3: 8'd7};
            4'd3:    return '{c1: 8'd3, c2: 8'd6, c3: 8'd1};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/wr_sched_if.sv
// Control/status bundle between the decoder control, the write scheduler and the write cell.
// WR_SCHED_ITER_EN adds the iter_num request field.
interface wr_sched_if #(
    parameter int A_WID = 8
) ();
    logic               start;
    logic               sin_in;
    logic               sin_valid;
    logic               hold;
`ifdef WR_SCHED_ITER_EN
    logic [3:0]         iter_num;
`endif
    logic [3:0]         fsm;
    logic [1:0]         cycle;
    logic               wr_en;
    logic               sin;
    logic [A_WID-1:0]   base_addr;
    logic [3*A_WID-1:0] addr_offset;
    logic               busy;
    logic               done;

`ifdef WR_SCHED_ITER_EN
    modport slave  (input  start, sin_in, sin_valid, hold, iter_num,
                    output fsm, cycle, wr_en, sin, base_addr, addr_offset, busy, done);
    modport master (output start, sin_in, sin_valid, hold, iter_num,
                    input  fsm, cycle, wr_en, sin, base_addr, addr_offset, busy, done);
`else
    modport slave  (input  start, sin_in, sin_valid, hold,
                    output fsm, cycle, wr_en, sin, base_addr, addr_offset, busy, done);
    modport master (output start, sin_in, sin_valid, hold,
                    input  fsm, cycle, wr_en, sin, base_addr, addr_offset, busy, done);
`endif

endinterface

// File: rtl/wr_offset_rom.sv
// Registered row -> packed offset triple lookup; fed the next row so its output lines up with cycle 1.
// Output is forced to zero whenever the scheduler will not be in UPDATE.
module wr_offset_rom
    import wr_sched_pkg::*;
#(
    parameter int A_WID = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_en,
    input  logic [ROW_W-1:0]   i_row,
    output logic [3*A_WID-1:0] o_offset
);

    off_triple_t        w_ent;
    logic [3*A_WID-1:0] r_offset;

    assign w_ent = offset_tbl(i_row);

    always_ff @(posedge clk) begin
        if (reset || !i_en) begin
            r_offset <= '0;
        end else begin
            r_offset <= {A_WID'(w_ent.c1), A_WID'(w_ent.c2), A_WID'(w_ent.c3)};
        end
    end

    assign o_offset = r_offset;

endmodule

// File: rtl/wr_sched.sv
// Write scheduler: LOAD streams a serial block, UPDATE walks parity rows issuing three offset writes each.
// Optional macro WR_SCHED_ITER_EN repeats the UPDATE sweep iter_num+1 times.
module wr_sched
    import wr_sched_pkg::*;
#(
    parameter int A_WID    = 8,
    parameter int Z        = 8,
    parameter int NUM_ROWS = 4,
    parameter int LOAD_LEN = 64
) (
    input  logic     clk,
    input  logic     reset,
    wr_sched_if.slave bus
);

    localparam int LCW = $clog2(LOAD_LEN) + 1;

    logic [3:0]       r_fsm,      w_fsm_nxt;
    logic [LCW-1:0]   r_load_cnt, w_load_cnt_nxt;
    logic [ROW_W-1:0] r_row,      w_row_nxt;
    logic [1:0]       r_cycle,    w_cycle_nxt;
    logic             r_wr_en,    w_wr_en_nxt;
    logic [A_WID-1:0] r_base,     w_base_nxt;
    logic             r_busy;
    logic             r_done;
    logic             w_load_last;
    logic             w_row_last;
    logic             w_sweep_last;
    logic             w_step;

    assign w_load_last = bus.sin_valid && (r_load_cnt == LCW'(LOAD_LEN - 1));
    assign w_row_last  = (r_row == ROW_W'(NUM_ROWS - 1));
    assign w_step      = !bus.hold && (r_cycle == CYC_3);

`ifdef WR_SCHED_ITER_EN
    logic [3:0] r_iter_left, w_iter_left_nxt;
    assign w_sweep_last = w_row_last && (r_iter_left == 4'd0);
`else
    assign w_sweep_last = w_row_last;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm      <= FSM_IDLE;
            r_load_cnt <= '0;
            r_row      <= '0;
            r_cycle    <= CYC_NONE;
            r_wr_en    <= 1'b0;
            r_base     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef WR_SCHED_ITER_EN
            r_iter_left <= '0;
`endif
        end else begin
            r_fsm      <= w_fsm_nxt;
            r_load_cnt <= w_load_cnt_nxt;
            r_row      <= w_row_nxt;
            r_cycle    <= w_cycle_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_base     <= w_base_nxt;
            r_busy     <= (w_fsm_nxt != FSM_IDLE);
            r_done     <= (w_fsm_nxt == FSM_DONE);
`ifdef WR_SCHED_ITER_EN
            r_iter_left <= w_iter_left_nxt;
`endif
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            FSM_IDLE: if (bus.start)                 w_fsm_nxt = FSM_LOAD;
            FSM_LOAD: if (w_load_last)               w_fsm_nxt = FSM_UPD;
            FSM_UPD:  if (w_step && w_sweep_last)    w_fsm_nxt = FSM_DONE;
            FSM_DONE:                                w_fsm_nxt = FSM_IDLE;
            default:                                 w_fsm_nxt = FSM_IDLE;
        endcase
    end

    // Next values for the registered outputs and counters; hold simply leaves them unchanged.
    always_comb begin
        w_load_cnt_nxt = r_load_cnt;
        w_row_nxt      = r_row;
        w_cycle_nxt    = r_cycle;
        w_wr_en_nxt    = r_wr_en;
        w_base_nxt     = r_base;
`ifdef WR_SCHED_ITER_EN
        w_iter_left_nxt = r_iter_left;
`endif
        case (r_fsm)
            FSM_IDLE: begin
                if (bus.start) begin
                    w_load_cnt_nxt = '0;
                    w_row_nxt      = '0;
                    w_base_nxt     = '0;
`ifdef WR_SCHED_ITER_EN
                    w_iter_left_nxt = bus.iter_num;
`endif
                end
            end
            FSM_LOAD: begin
                if (bus.sin_valid) w_load_cnt_nxt = r_load_cnt + LCW'(1);
                if (w_load_last) begin
                    w_row_nxt   = '0;
                    w_base_nxt  = '0;
                    w_cycle_nxt = CYC_1;
                    w_wr_en_nxt = 1'b1;
                end
            end
            FSM_UPD: begin
                if (!bus.hold) begin
                    if (r_cycle != CYC_3) begin
                        w_cycle_nxt = r_cycle + 2'd1;
                    end else if (w_sweep_last) begin
                        w_cycle_nxt = CYC_NONE;
                        w_wr_en_nxt = 1'b0;
                    end else if (w_row_last) begin
                        w_row_nxt   = '0;
                        w_base_nxt  = '0;
                        w_cycle_nxt = CYC_1;
`ifdef WR_SCHED_ITER_EN
                        w_iter_left_nxt = r_iter_left - 4'd1;
`endif
                    end else begin
                        w_row_nxt   = r_row + ROW_W'(1);
                        w_base_nxt  = r_base + A_WID'(Z);
                        w_cycle_nxt = CYC_1;
                    end
                end
            end
            default: ;
        endcase
    end

    wr_offset_rom #(
        .A_WID (A_WID)
    ) u_rom (
        .clk      (clk),
        .reset    (reset),
        .i_en     (w_fsm_nxt == FSM_UPD),
        .i_row    (w_row_nxt),
        .o_offset (bus.addr_offset)
    );

    assign bus.fsm       = r_fsm;
    assign bus.cycle     = r_cycle;
    assign bus.wr_en     = r_wr_en;
    assign bus.base_addr = r_base;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    // The write cell registers sin itself, so it is passed through combinationally.
    assign bus.sin       = bus.sin_in & bus.sin_valid & r_fsm[1];

endmodule

// File: tb/tb_wr_sched.sv
// Directed self-checking bench for wr_sched (default build, WR_SCHED_ITER_EN undefined).
module tb_wr_sched;

    logic clk;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    logic [23:0] exp_off [4] = '{24'h010305, 24'h020406, 24'h000507, 24'h030601};

    wr_sched_if #(.A_WID(8)) bus ();

    wr_sched #(
        .A_WID    (8),
        .Z        (8),
        .NUM_ROWS (4),
        .LOAD_LEN (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {fsm, cycle, wr_en, sin, base_addr, addr_offset, busy, done}
    task automatic test_reset();
        logic [41:0] act, exp;
        exp = {4'b0001, 2'd0, 1'b0, 1'b0, 8'd0, 24'd0, 1'b0, 1'b0};
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        act = {bus.fsm, bus.cycle, bus.wr_en, bus.sin, bus.base_addr, bus.addr_offset, bus.busy, bus.done};
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL reset_held: got %h expected %h", act, exp);
        end
        reset = 1'b0;
        bus.sin_in = 1'b1;
        bus.sin_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            act = {bus.fsm, bus.cycle, bus.wr_en, bus.sin, bus.base_addr, bus.addr_offset, bus.busy, bus.done};
            n_chk++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL reset_idle[%0d]: got %h expected %h", i, act, exp);
            end
        end
        bus.sin_in = 1'b0;
        bus.sin_valid = 1'b0;
    endtask

    // gap=0: sin_valid every cycle (64 LOAD cycles); gap=1: valid on odd cycles only (128 LOAD cycles)
    task automatic test_load(input int gap);
        logic [4:0]  act, exp;
        logic [12:0] act_u, exp_u;
        int len;
        len = (gap != 0) ? 128 : 64;
        bus.start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < len; i++) begin
            bus.sin_valid = (gap == 0) || (i % 2 == 1);
            bus.sin_in    = ((i >> 1) % 2 == 0);
            bus.start     = (i == 5) || (i == 40);
            #1;
            act = {bus.fsm, bus.sin};
            exp = {4'b0010, bus.sin_in & bus.sin_valid};
            n_chk++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL load[%0d]: got fsm/sin %b expected %b", i, act, exp);
            end
            @(negedge clk);
        end
        bus.start     = 1'b0;
        bus.sin_valid = 1'b0;
        bus.sin_in    = 1'b0;
        act_u = {bus.fsm, bus.cycle, bus.wr_en, bus.base_addr[5:0]};
        exp_u = {4'b0100, 2'd1, 1'b1, 6'd0};
        n_chk++;
        if (act_u !== exp_u) begin
            n_err++;
            $display("FAIL load_to_update: got %b expected %b", act_u, exp_u);
        end
    endtask

    // Called at the UPDATE entry cycle; hr/hc select where hold is asserted for hl cycles.
    task automatic test_update(input int hr, input int hc, input int hl);
        logic [40:0] act, exp;
        logic [8:0]  act_d, exp_d;
        int r, c, held;
        logic h;
        r = 0; c = 1; held = 0;
        for (int t = 0; t < 40; t++) begin
            act = {bus.fsm, bus.cycle, bus.wr_en, bus.base_addr, bus.addr_offset, bus.busy, bus.done};
            exp = {4'b0100, 2'(c), 1'b1, 8'(r * 8), exp_off[r], 1'b1, 1'b0};
            n_chk++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL update[t=%0d row=%0d cyc=%0d]: got %h expected %h", t, r, c, act, exp);
            end
            h = (r == hr) && (c == hc) && (held < hl);
            bus.hold = h;
            @(negedge clk);
            if (h) held++;
            else if (c < 3) c++;
            else if (r == 3) break;
            else begin
                r++;
                c = 1;
            end
        end
        bus.hold = 1'b0;
        act_d = {bus.fsm, bus.cycle, bus.wr_en, bus.busy, bus.done};
        exp_d = {4'b1000, 2'd0, 1'b0, 1'b1, 1'b1};
        n_chk++;
        if (act_d !== exp_d) begin
            n_err++;
            $display("FAIL done_pulse: got %b expected %b", act_d, exp_d);
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        exp_d = {4'b0001, 2'd0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 2; i++) begin
            act_d = {bus.fsm, bus.cycle, bus.wr_en, bus.busy, bus.done};
            n_chk++;
            if (act_d !== exp_d) begin
                n_err++;
                $display("FAIL back_to_idle[%0d]: got %b expected %b", i, act_d, exp_d);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic [40:0] act, exp;
        logic [8:0]  act_d, exp_d;
        test_load(0);
        repeat (6) @(negedge clk);
        act = {bus.fsm, bus.cycle, bus.wr_en, bus.base_addr, bus.addr_offset, bus.busy, bus.done};
        exp = {4'b0100, 2'd1, 1'b1, 8'd16, 24'h000507, 1'b1, 1'b0};
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL mid_row2: got %h expected %h", act, exp);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        act = {bus.fsm, bus.cycle, bus.wr_en, bus.base_addr, bus.addr_offset, bus.busy, bus.done};
        exp = {4'b0001, 2'd0, 1'b0, 8'd0, 24'd0, 1'b0, 1'b0};
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL mid_reset: got %h expected %h", act, exp);
        end
        exp_d = {4'b0001, 2'd0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            act_d = {bus.fsm, bus.cycle, bus.wr_en, bus.busy, bus.done};
            n_chk++;
            if (act_d !== exp_d) begin
                n_err++;
                $display("FAIL after_reset[%0d]: got %b expected %b", i, act_d, exp_d);
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.sin_in    = 1'b0;
        bus.sin_valid = 1'b0;
        bus.hold      = 1'b0;
`ifdef WR_SCHED_ITER_EN
        bus.iter_num  = 4'd0;
`endif
        test_reset();
        test_load(0);
        test_update(15, 0, 0);
        test_load(0);
        test_update(1, 2, 3);
        test_reset_mid();
        test_load(0);
        test_update(15, 0, 0);
        test_load(1);
        test_update(3, 3, 2);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
